// File: rtl/noc_mem_target_pkg.sv
// Shared NoC definitions for the memory endpoint: flit geometry, message
// types, header flit layout and the payload flit-count helper.
package noc_mem_target_pkg;

    localparam int NOC_DATA_WIDTH   = 512;
    localparam int NOC_DATA_BYTES   = NOC_DATA_WIDTH / 8;
    localparam int NOC_DATA_BYTES_W = $clog2(NOC_DATA_BYTES);
    localparam int MSG_LENGTH_WIDTH = 8;
    localparam int MSG_TYPE_WIDTH   = 8;
    localparam int CHIP_ID_WIDTH    = 14;
    localparam int XY_COORD_WIDTH   = 8;
    localparam int FBITS_WIDTH      = 4;
    localparam int ADDR_WIDTH       = 48;
    localparam int DATA_SIZE_WIDTH  = 16;

    localparam int HDR_USED_WIDTH = DATA_SIZE_WIDTH + ADDR_WIDTH + FBITS_WIDTH
                                  + 2 * (CHIP_ID_WIDTH + 2 * XY_COORD_WIDTH)
                                  + MSG_LENGTH_WIDTH + MSG_TYPE_WIDTH;

    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM      = 8'd19;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM     = 8'd20;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM_ACK = 8'd21;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM_ACK  = 8'd22;

    // Header flit; msg_type sits in the least significant bits.
    typedef struct packed {
        logic [NOC_DATA_WIDTH-HDR_USED_WIDTH-1:0] rsvd;
        logic [DATA_SIZE_WIDTH-1:0]  data_size;
        logic [ADDR_WIDTH-1:0]       addr;
        logic [FBITS_WIDTH-1:0]      fbits;
        logic [XY_COORD_WIDTH-1:0]   src_y_coord;
        logic [XY_COORD_WIDTH-1:0]   src_x_coord;
        logic [CHIP_ID_WIDTH-1:0]    src_chip_id;
        logic [XY_COORD_WIDTH-1:0]   dst_y_coord;
        logic [XY_COORD_WIDTH-1:0]   dst_x_coord;
        logic [CHIP_ID_WIDTH-1:0]    dst_chip_id;
        logic [MSG_LENGTH_WIDTH-1:0] msg_len;
        logic [MSG_TYPE_WIDTH-1:0]   msg_type;
    } noc_hdr_flit;

    // Number of payload flits needed to carry data_size bytes (rounded up).
    function automatic logic [MSG_LENGTH_WIDTH-1:0] flits_for_size(
        input logic [DATA_SIZE_WIDTH-1:0] ds);
        logic [DATA_SIZE_WIDTH-1:0] q;
        q = ds >> NOC_DATA_BYTES_W;
        return MSG_LENGTH_WIDTH'(q) + MSG_LENGTH_WIDTH'(|ds[NOC_DATA_BYTES_W-1:0]);
    endfunction

endpackage

// File: rtl/noc_mem_target_ram.sv
// Word array behind the memory endpoint: one synchronous write port and
// one combinational read port, kept separate so a macro can replace it.
module noc_mem_target_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/noc_mem_target.sv
// NoC memory endpoint: services STORE_MEM / LOAD_MEM messages from an
// internal word array and returns the matching ack (plus load payload).
module noc_mem_target
    import noc_mem_target_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int MY_X  = 1,
    parameter int MY_Y  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      noc0_mem_val,
    input  logic [NOC_DATA_WIDTH-1:0] noc0_mem_data,
    output logic                      noc0_mem_rdy,
    output logic                      mem_noc0_val,
    output logic [NOC_DATA_WIDTH-1:0] mem_noc0_data,
    input  logic                      mem_noc0_rdy,
    output logic                      bad_msg_val
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, WR_PAYLOAD, DRAIN, SEND_HDR, RD_PAYLOAD
    } state_t;

    state_t                      state_q;
    noc_hdr_flit                 hdr_q, in_hdr, rsp_hdr;
    logic [MSG_LENGTH_WIDTH-1:0] rem_q, flit_cnt_q, in_flit_cnt;
    logic [AW-1:0]               idx_q, idx_d;
    logic                        bad_q;
    logic                        in_xfer, out_xfer, ram_we, is_load;
    logic [NOC_DATA_WIDTH-1:0]   ram_rdata;
    logic                        unused_hdr_bits;

    assign in_hdr      = noc_hdr_flit'(noc0_mem_data);
    assign in_flit_cnt = flits_for_size(in_hdr.data_size);
    assign is_load     = (hdr_q.msg_type == MSG_TYPE_LOAD_MEM);

    assign noc0_mem_rdy = !rst && (state_q == IDLE || state_q == WR_PAYLOAD || state_q == DRAIN);
    assign mem_noc0_val = (state_q == SEND_HDR) || (state_q == RD_PAYLOAD);
    assign bad_msg_val  = bad_q;

    assign in_xfer  = noc0_mem_val && noc0_mem_rdy;
    assign out_xfer = mem_noc0_val && mem_noc0_rdy;
    assign ram_we   = in_xfer && (state_q == WR_PAYLOAD);
    assign idx_d    = idx_q + AW'(1);

    // Fields of the request header that the response never reflects.
    assign unused_hdr_bits = ^{hdr_q.rsvd, hdr_q.dst_chip_id, hdr_q.dst_x_coord,
                               hdr_q.dst_y_coord, hdr_q.msg_len};

    noc_mem_target_ram #(
        .DEPTH (DEPTH),
        .WIDTH (NOC_DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (noc0_mem_data),
        .raddr (idx_q),
        .rdata (ram_rdata)
    );

    // Response header: route back to the requester, echo addr/size.
    always_comb begin
        rsp_hdr             = '0;
        rsp_hdr.dst_chip_id = hdr_q.src_chip_id;
        rsp_hdr.dst_x_coord = hdr_q.src_x_coord;
        rsp_hdr.dst_y_coord = hdr_q.src_y_coord;
        rsp_hdr.fbits       = hdr_q.fbits;
        rsp_hdr.src_x_coord = XY_COORD_WIDTH'(MY_X);
        rsp_hdr.src_y_coord = XY_COORD_WIDTH'(MY_Y);
        rsp_hdr.addr        = hdr_q.addr;
        rsp_hdr.data_size   = hdr_q.data_size;
        rsp_hdr.msg_type    = is_load ? MSG_TYPE_LOAD_MEM_ACK : MSG_TYPE_STORE_MEM_ACK;
        rsp_hdr.msg_len     = is_load ? flit_cnt_q : '0;
    end

    // Outgoing flit mux; zero whenever nothing is being offered.
    always_comb begin
        mem_noc0_data = '0;
        case (state_q)
            SEND_HDR:   mem_noc0_data = rsp_hdr;
            RD_PAYLOAD: mem_noc0_data = ram_rdata;
            default:    mem_noc0_data = '0;
        endcase
    end

    // Message FSM; rem_q counts flits still to move in the current phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hdr_q      <= '0;
            rem_q      <= '0;
            flit_cnt_q <= '0;
            idx_q      <= '0;
            bad_q      <= 1'b0;
        end else begin
            bad_q <= 1'b0;
            case (state_q)
                IDLE: if (in_xfer) begin
                    hdr_q      <= in_hdr;
                    idx_q      <= in_hdr.addr[NOC_DATA_BYTES_W +: AW];
                    rem_q      <= in_hdr.msg_len;
                    flit_cnt_q <= '0;
                    case (in_hdr.msg_type)
                        MSG_TYPE_STORE_MEM:
                            state_q <= (in_hdr.msg_len == '0) ? SEND_HDR : WR_PAYLOAD;
                        MSG_TYPE_LOAD_MEM: begin
                            flit_cnt_q <= in_flit_cnt;
                            rem_q      <= in_flit_cnt;
                            state_q    <= SEND_HDR;
                        end
                        default: begin
                            bad_q <= 1'b1;
                            if (in_hdr.msg_len != '0) state_q <= DRAIN;
                        end
                    endcase
                end
                WR_PAYLOAD: if (in_xfer) begin
                    idx_q <= idx_d;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == 1) state_q <= SEND_HDR;
                end
                DRAIN: if (in_xfer) begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == 1) state_q <= IDLE;
                end
                SEND_HDR: if (out_xfer) begin
                    state_q <= (is_load && flit_cnt_q != '0) ? RD_PAYLOAD : IDLE;
                end
                RD_PAYLOAD: if (out_xfer) begin
                    idx_q <= idx_d;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == 1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_mem_target.sv
// Scoreboard bench for noc_mem_target (DEPTH=16 so the wrap case is reachable).
module tb_noc_mem_target;
    import noc_mem_target_pkg::*;

    localparam int DEPTH = 16;
    typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  noc0_mem_val;
    flit_t noc0_mem_data;
    logic  noc0_mem_rdy;
    logic  mem_noc0_val;
    flit_t mem_noc0_data;
    logic  mem_noc0_rdy;
    logic  bad_msg_val;

    noc_mem_target #(.DEPTH(DEPTH), .MY_X(1), .MY_Y(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .noc0_mem_val  (noc0_mem_val),
        .noc0_mem_data (noc0_mem_data),
        .noc0_mem_rdy  (noc0_mem_rdy),
        .mem_noc0_val  (mem_noc0_val),
        .mem_noc0_data (mem_noc0_data),
        .mem_noc0_rdy  (mem_noc0_rdy),
        .bad_msg_val   (bad_msg_val)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    bad_cnt = 0;
    flit_t exp_q [$];
    string tag_q [$];
    flit_t mm [DEPTH];   // reference memory contents
    bit    hold_v = 0;
    flit_t hold_d;

    task automatic chk(input string tag, input flit_t obs, input flit_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic flit_t rnd_flit();
        flit_t f;
        for (int i = 0; i < NOC_DATA_WIDTH / 32; i++) f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    function automatic flit_t mk_req(input logic [7:0] t, input logic [7:0] len,
                                     input logic [47:0] a, input logic [15:0] ds,
                                     input logic [7:0] sx);
        noc_hdr_flit h;
        h = '0;
        h.msg_type = t; h.msg_len = len; h.addr = a; h.data_size = ds;
        h.src_chip_id = 14'd5; h.src_x_coord = sx; h.src_y_coord = 8'd2; h.fbits = 4'd3;
        h.dst_x_coord = 8'd1;
        return flit_t'(h);
    endfunction

    function automatic flit_t mk_ack(input logic [7:0] t, input logic [7:0] len,
                                     input logic [47:0] a, input logic [15:0] ds,
                                     input logic [7:0] dx);
        noc_hdr_flit h;
        h = '0;
        h.msg_type = t; h.msg_len = len; h.addr = a; h.data_size = ds;
        h.dst_chip_id = 14'd5; h.dst_x_coord = dx; h.dst_y_coord = 8'd2; h.fbits = 4'd3;
        h.src_x_coord = 8'd1; h.src_y_coord = 8'd0;
        return flit_t'(h);
    endfunction

    function automatic int word_of(input logic [47:0] a);
        return int'((a >> 6) % DEPTH);
    endfunction

    function automatic void push(input string tag, input flit_t f);
        exp_q.push_back(f);
        tag_q.push_back(tag);
    endfunction

    // Output monitor: pops the scoreboard on every transfer, checks hold-stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("hold_val", flit_t'(mem_noc0_val), flit_t'(1));
                chk("hold_data", mem_noc0_data, hold_d);
            end
            hold_v = mem_noc0_val && !mem_noc0_rdy;
            hold_d = mem_noc0_data;
            if (mem_noc0_val && mem_noc0_rdy) begin
                if (exp_q.size() == 0) chk("spurious_flit", flit_t'(exp_q.size()), flit_t'(1));
                else chk(tag_q.pop_front(), mem_noc0_data, exp_q.pop_front());
            end
            if (bad_msg_val) bad_cnt++;
        end
    end

    task automatic send(input flit_t f);
        int t = 0;
        noc0_mem_val  = 1'b1;
        noc0_mem_data = f;
        @(negedge clk);
        while (!noc0_mem_rdy && t < 50) begin @(negedge clk); t++; end
        if (!noc0_mem_rdy) chk("send_timeout", flit_t'(noc0_mem_rdy), flit_t'(1));
        @(posedge clk); #1;
        noc0_mem_val = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin @(negedge clk); t++; end
        chk("drain", flit_t'(exp_q.size()), flit_t'(0));
        @(posedge clk); #1;
    endtask

    task automatic do_store(input logic [47:0] a, input logic [15:0] ds,
                            input flit_t w [$], input logic [7:0] sx);
        int k;
        push("st_ack", mk_ack(MSG_TYPE_STORE_MEM_ACK, 8'd0, a, ds, sx));
        send(mk_req(MSG_TYPE_STORE_MEM, 8'(w.size()), a, ds, sx));
        k = word_of(a);
        foreach (w[i]) begin
            send(w[i]);
            mm[k] = w[i];
            k = (k + 1) % DEPTH;
        end
        @(negedge clk);
        chk("st_ack_lat", flit_t'(mem_noc0_val), flit_t'(1));
        drain();
    endtask

    task automatic ld_setup(input logic [47:0] a, input logic [15:0] ds, input logic [7:0] sx);
        int n, k;
        n = (ds + 63) / 64;
        k = word_of(a);
        push("ld_hdr", mk_ack(MSG_TYPE_LOAD_MEM_ACK, 8'(n), a, ds, sx));
        for (int i = 0; i < n; i++) begin
            push($sformatf("ld_data%0d", i), mm[k]);
            k = (k + 1) % DEPTH;
        end
        send(mk_req(MSG_TYPE_LOAD_MEM, 8'd0, a, ds, sx));
    endtask

    task automatic do_load(input logic [47:0] a, input logic [15:0] ds, input logic [7:0] sx);
        ld_setup(a, ds, sx);
        @(negedge clk);
        chk("ld_hdr_lat", flit_t'(mem_noc0_val), flit_t'(1));
        drain();
    endtask

    initial begin
        flit_t w [$];
        flit_t fa, fb;
        logic [3:0] bp;
        int k;

        rst = 1'b1; noc0_mem_val = 1'b0; noc0_mem_data = '0; mem_noc0_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_val", flit_t'(mem_noc0_val), flit_t'(0));
        chk("rst_data", mem_noc0_data, '0);
        chk("rst_bad", flit_t'(bad_msg_val), flit_t'(0));
        chk("rst_rdy", flit_t'(noc0_mem_rdy), flit_t'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", flit_t'(noc0_mem_rdy), flit_t'(1));
        @(posedge clk); #1;

        // Preload words 0..3
        w = {rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit()};
        do_store(48'h0, 16'd256, w, 8'd3);

        // Store round trip at 0x80
        fa = rnd_flit(); fb = rnd_flit();
        w = {fa, fb};
        do_store(48'h80, 16'd100, w, 8'd0);
        do_load(48'h80, 16'd100, 8'd0);

        // Same load under output backpressure 1,0,0,1
        ld_setup(48'h80, 16'd100, 8'd0);
        bp = 4'b1001;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            mem_noc0_rdy = bp[3 - (k % 4)];
            @(posedge clk); #1;
            k++;
        end
        mem_noc0_rdy = 1'b1;
        drain();

        // Zero-length load, then a header the very next cycle
        push("zl_hdr", mk_ack(MSG_TYPE_LOAD_MEM_ACK, 8'd0, 48'h40, 16'd0, 8'd0));
        send(mk_req(MSG_TYPE_LOAD_MEM, 8'd0, 48'h40, 16'd0, 8'd0));
        @(negedge clk);
        chk("zl_val", flit_t'(mem_noc0_val), flit_t'(1));
        @(negedge clk);
        chk("zl_idle_val", flit_t'(mem_noc0_val), flit_t'(0));
        chk("zl_idle_rdy", flit_t'(noc0_mem_rdy), flit_t'(1));
        @(posedge clk); #1;
        do_load(48'h0, 16'd64, 8'd0);

        // Wrap: words 15 and 0
        w = {rnd_flit(), rnd_flit()};
        do_store(48'h3C0, 16'd128, w, 8'd0);
        do_load(48'h3C0, 16'd128, 8'd0);

        // Unsupported type with 3 trailing flits
        bad_cnt = 0;
        send(mk_req(8'h7F, 8'd3, 48'h0, 16'd192, 8'd0));
        for (int i = 0; i < 3; i++) send(rnd_flit());
        repeat (3) @(posedge clk); #1;
        chk("bad_pulse", flit_t'(bad_cnt), flit_t'(1));
        chk("bad_idle_rdy", flit_t'(noc0_mem_rdy), flit_t'(1));
        do_load(48'h0, 16'd256, 8'd0);

        // Reset after 1 of 4 store payload flits
        fa = rnd_flit();
        send(mk_req(MSG_TYPE_STORE_MEM, 8'd4, 48'h0, 16'd256, 8'd0));
        send(fa);
        mm[0] = fa;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", flit_t'(noc0_mem_rdy), flit_t'(0));
        chk("mid_rst_val", flit_t'(mem_noc0_val), flit_t'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_noack", flit_t'(mem_noc0_val), flit_t'(0));
        chk("post_rst_rdy", flit_t'(noc0_mem_rdy), flit_t'(1));
        @(posedge clk); #1;
        do_load(48'h0, 16'd256, 8'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_mem_target.md
# noc_mem_target

NoC-attached memory endpoint. It sits at the far end of noc0, at tile (1,0), downstream of the memory tester and the TCP buffer writers. It receives `MSG_TYPE_STORE_MEM` and `MSG_TYPE_LOAD_MEM` messages, services them from an internal flop-based word array, and returns a `MSG_TYPE_STORE_MEM_ACK` header or a `MSG_TYPE_LOAD_MEM_ACK` header followed by payload flits. It is the behavioural memory used by the memory-path testbenches and by the SoC simulation build.

## Interface
- `DEPTH`, 256: array depth in `NOC_DATA_WIDTH` words; must be a power of 2.
- `MY_X`, 1: own x coordinate, placed in response `src_x_coord`.
- `MY_Y`, 0: own y coordinate, placed in response `src_y_coord`.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `noc0_mem_val`  in  1  incoming flit valid.
- `noc0_mem_data`  in  `NOC_DATA_WIDTH`  incoming flit (header or payload).
- `noc0_mem_rdy`  out  1  block accepts the incoming flit.
- `mem_noc0_val`  out  1  outgoing flit valid.
- `mem_noc0_data`  out  `NOC_DATA_WIDTH`  outgoing flit.
- `mem_noc0_rdy`  in  1  network accepts the outgoing flit.
- `bad_msg_val`  out  1  one-cycle pulse when a header with an unsupported `msg_type` is consumed.

## Operation
- Transfer rule: a flit transfers when val and rdy are both high on a rising edge.
- Word index: `(addr >> NOC_DATA_BYTES_W)`, taken modulo `DEPTH` (low `$clog2(DEPTH)` bits). Low address bits are ignored, so an unaligned address acts as if aligned down. Consecutive flits use index+1 and wrap from `DEPTH-1` to 0.
- States:
  - IDLE: `rdy`=1. When a header is accepted, latch it.
    - STORE_MEM: go to WR_PAYLOAD, or to SEND_HDR if `msg_len`=0.
    - LOAD_MEM: set `flit_cnt = ceil(data_size / NOC_DATA_BYTES)` and go to SEND_HDR.
    - Any other type: pulse `bad_msg_val`. Go to DRAIN if `msg_len`≠0, else stay in IDLE.
  - WR_PAYLOAD: `rdy`=1. Each accepted flit is written to the array at the edge it transfers, and the index increments. After `msg_len` flits, go to SEND_HDR.
  - DRAIN: `rdy`=1. Discard `msg_len` flits, then go to IDLE.
  - SEND_HDR: `val`=1, `rdy`=0. The response header is built as follows:
    - `dst_chip_id`, `dst_x_coord`, `dst_y_coord`, `fbits` are copied from the request's `src_*` fields.
    - `src_x_coord`/`src_y_coord` = `MY_X`/`MY_Y`; other `src_*` fields = 0.
    - `addr` and `data_size` are echoed from the request.
    - STORE case: `msg_type` = STORE_MEM_ACK, `msg_len` = 0.
    - LOAD case: `msg_type` = LOAD_MEM_ACK, `msg_len` = `flit_cnt`.
    - On transfer: STORE goes to IDLE. LOAD goes to RD_PAYLOAD, or to IDLE if `flit_cnt`=0.
  - RD_PAYLOAD: `val`=1, `rdy`=0. `mem_noc0_data` = array[index], read combinationally.
    - Each transfer increments the index.
    - After `flit_cnt` transfers, go to IDLE.
    - Full words are sent. The consumer masks padding on the last flit.
- Data is held stable while `val`=1 and `rdy`=0.
- All counters are `MSG_LENGTH_WIDTH` bits.
- `ceil` is computed as the shift, plus 1 if `data_size[NOC_DATA_BYTES_W-1:0]`≠0.

## Timing
- Reset values:
  - State = IDLE. Header register and counters = 0.
  - `mem_noc0_val`=0, `mem_noc0_data`=0, `bad_msg_val`=0.
  - `noc0_mem_rdy` is forced 0 while `rst`=1.
  - Array contents are not reset (X until written).
- Reset mid-message returns the block to IDLE next cycle. Any partial store keeps the words already written. The remaining flits of that message are not specially handled.
- Store: header accepted at cycle N, payload accepted from N+1 at 1 flit/cycle. Last payload transfers at M; ack `val`=1 at M+1.
- Load: header accepted at N; response header `val`=1 at N+1. First payload `val`=1 the cycle after the header transfers.
- Read-after-write: a load that follows a store sees the stored data. The ack is only sent after all writes have completed.
- No overlap between messages: a new header is accepted only in IDLE, the cycle after the previous response completes.

## Structure
- `noc_hdr_flit`, `MSG_TYPE_*` and `NOC_DATA_*` come from `noc_defs.vh`/`packet_defs.vh`.
- `MSG_TYPE_LOAD_MEM_ACK` is added to `packet_defs.vh` next to `MSG_TYPE_STORE_MEM_ACK`.
- State enum is local to the module.
- One sub-module, `noc_mem_target_ram`:
  - `DEPTH`×`NOC_DATA_WIDTH` array.
  - Write port: we/waddr/wdata.
  - Combinational read port.
  - It can later be swapped for an SRAM macro.

## Test plan
- Store round trip: STORE addr 0x80, `data_size` 100, `msg_len` 2, payload A, B, request src x=0 -> ack with dst x=0, src x=1, `msg_len` 0, addr 0x80. Then LOAD addr 0x80, `data_size` 100 -> header `msg_len` 2, `data_size` 100, payload A then B.
- Backpressure: same load with `mem_noc0_rdy` toggling 1,0,0,1 -> `val` held, data stable, no flit duplicated or skipped.
- Zero-length load: LOAD `data_size` 0 -> single header with `msg_len` 0, back to IDLE, next header accepted the cycle after.
- Wrap: `DEPTH`=16, STORE addr 0x3C0, 2 flits X, Y -> words 15 and 0. LOAD addr 0x3C0, size 128 -> X, Y.
- Bad type: header type 0x7F, `msg_len` 3, followed by 3 flits -> `bad_msg_val` pulses once, no response, array unchanged. A following LOAD is serviced normally.
- Reset mid-store: `rst` after 1 of 4 payload flits -> `rdy`=0 during reset, IDLE after, no ack emitted. Word 0 written, words 1–3 unchanged.
